alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits; legal values are powers of two from 8 to 64.
REQ-002 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_vld  input  1  upstream offers an operation.
REQ-006 SHALL have port in_rdy  output  1  block accepts an operation this cycle.
REQ-007 SHALL have port op_in  input  4  operation code, encoded per REQ-014.
REQ-008 SHALL have ports a_in and b_in  input  WIDTH  operand A and operand B.
REQ-009 SHALL have port tag_in  input  TAG_W  sideband tag, passed through unmodified.
REQ-010 SHALL have port out  output  WIDTH  result.
REQ-011 SHALL have port out_tag  output  TAG_W  tag of the result beat.
REQ-012 SHALL have ports out_vld (output, 1) and out_rdy (input, 1)  result handshake.
REQ-013 SHALL have port out_err  output  1  high with a result beat whose op code was illegal.

Function
REQ-014 SHALL use these op codes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU; codes 11-15 are illegal.
REQ-015 SHALL accept a beat on a cycle where in_vld and in_rdy are both high.
REQ-016 SHALL be a two-stage pipeline: stage 1 registers the accepted operands, op and tag; stage 2 registers the result, tag and error flag.
REQ-017 SHALL present the result on out at least 2 cycles after acceptance (exactly 2 with out_rdy held high), with out_vld high.
REQ-018 SHALL advance stage 2 when stage 2 is empty or out_rdy is high; stage 1 advances into stage 2 under the same condition.
REQ-019 SHALL drive in_rdy = (stage 1 empty) OR (stage 2 empty) OR out_rdy, combinationally; the path from out_rdy to in_rdy is the only combinational path.
REQ-020 SHALL sustain one beat per cycle with out_rdy held high; an accept and a drain in the same cycle SHALL lose and duplicate no beat.
REQ-021 SHALL hold out, out_tag, out_err and out_vld stable while out_vld is high and out_rdy is low.
REQ-022 SHALL compute ADD and SUB modulo 2^WIDTH; the carry is discarded and no overflow is flagged.
REQ-023 SHALL use only b[log2(WIDTH)-1:0] as the shift amount for SLL, SRL and SRA; SRA SHALL replicate a[WIDTH-1].
REQ-024 SHALL produce 1 for SLT when A < B as signed values and for SLTU when A < B as unsigned values, otherwise 0, zero-extended to WIDTH.
REQ-025 SHALL produce a beat with out = 0 for NOP.
REQ-026 SHALL produce a beat with out = 0 and out_err = 1 for an illegal op; out_err SHALL be 0 for all legal ops.
REQ-027 SHALL NOT change pipeline state when in_vld is low and nothing drains; out_vld SHALL be low whenever stage 2 is empty.

Reset
REQ-028 SHALL, on rst high, immediately clear both stage-valid flags and set out, out_tag and out_err to 0; out_vld is then 0 and in_rdy is 1.
REQ-029 SHALL discard in-flight beats when rst is asserted mid-operation and SHALL emit no beat on the first cycle after rst deasserts.

Configuration
REQ-030 SHALL, when macro ALU_PIPE_ERR_CNT_EN is defined, add output port err_cnt (8 bits, reset 0) that increments on each illegal-op beat accepted at the input and saturates at 255.
REQ-031 SHALL, when ALU_PIPE_ERR_CNT_EN is undefined, omit the err_cnt port and counter; all other behaviour SHALL be identical.

Verification (WIDTH=32, TAG_W=4)
REQ-032 SHALL cover: ADD a=0xFFFFFFFF, b=1, tag=3, out_rdy=1 -> out=0, out_tag=3, out_vld high exactly 2 cycles after accept.
REQ-033 SHALL cover: SRA a=0x80000000, b=0x24 -> out=0xF8000000 (shift by 4); SLT a=0xFFFFFFFF, b=0 -> 1; SLTU same operands -> 0.
REQ-034 SHALL cover: 4 back-to-back ops with out_rdy held low -> 2 beats accepted, then in_rdy=0 and out stable; out_rdy raised -> 4 beats delivered in order, no loss or duplication.
REQ-035 SHALL cover: op=12 -> out=0, out_err=1; with ALU_PIPE_ERR_CNT_EN defined, err_cnt=1, and 300 illegal ops -> err_cnt=255.
REQ-036 SHALL cover: rst pulsed with both stages full -> out_vld=0 and in_rdy=1 immediately, no stale beat after release.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage ALU pipeline with valid/ready handshaking on both sides.
// Stage 1 captures the accepted operands, op code and tag. Stage 2 holds the
// computed result, tag and illegal-op flag until the consumer takes it.
// Optional feature: define ALU_PIPE_ERR_CNT_EN to add an 8-bit saturating
// count of illegal-op beats accepted at the input (port err_cnt).
module alu_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [3:0]       op_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [TAG_W-1:0] tag_in,
   output logic [WIDTH-1:0] out,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic             out_err
`ifdef ALU_PIPE_ERR_CNT_EN
   ,
   output logic [7:0]       err_cnt
`endif
);

   localparam int SH_W = $clog2(WIDTH);

   // Result and illegal-op flag for one operation, packed as {err, result}.
   function automatic logic [WIDTH:0] alu_calc(input logic [3:0]       op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      logic signed [WIDTH-1:0] a_s;
      logic signed [WIDTH-1:0] b_s;
      logic [SH_W-1:0]         sh;
      logic [WIDTH-1:0]        r;
      logic                    err;
      a_s = a;
      b_s = b;
      sh  = b[SH_W-1:0];
      r   = '0;
      err = 1'b0;
      case (op)
         4'd0:  r = '0;
         4'd1:  r = a + b;
         4'd2:  r = a - b;
         4'd3:  r = a & b;
         4'd4:  r = a | b;
         4'd5:  r = a ^ b;
         4'd6:  r = a << sh;
         4'd7:  r = a >> sh;
         4'd8:  r = a_s >>> sh;
         4'd9:  r = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
         4'd10: r = {{(WIDTH-1){1'b0}}, (a < b)};
         default: begin
            r   = '0;
            err = 1'b1;
         end
      endcase
      return {err, r};
   endfunction

   logic             vld_p1;
   logic [3:0]       op_p1;
   logic [WIDTH-1:0] a_p1;
   logic [WIDTH-1:0] b_p1;
   logic [TAG_W-1:0] tag_p1;

   logic             vld_p2;
   logic [WIDTH-1:0] res_p2;
   logic [TAG_W-1:0] tag_p2;
   logic             err_p2;

   logic             adv_p2;
   logic             accept;
   logic [WIDTH:0]   calc_p1;

   // Stage 2 may take a new beat when it is empty or its beat is leaving now;
   // this out_rdy -> in_rdy path is the only combinational one through the block.
   assign adv_p2  = !vld_p2 || out_rdy;
   assign in_rdy  = !vld_p1 || !vld_p2 || out_rdy;
   assign accept  = in_vld && in_rdy;
   assign calc_p1 = alu_calc(op_p1, a_p1, b_p1);

   assign out     = res_p2;
   assign out_tag = tag_p2;
   assign out_err = err_p2;
   assign out_vld = vld_p2;

   // ---- stage 1: valid flag; reloads whenever it has room (empty or emptying)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
      end else if (in_rdy) begin
         vld_p1 <= in_vld;
      end
   end

   // Stage 1 data: captured only on an accepted beat, never needs clearing.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_p1  <= op_in;
         a_p1   <= a_in;
         b_p1   <= b_in;
         tag_p1 <= tag_in;
      end
   end

   // ---- stage 2: result register, held while the consumer stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p2 <= 1'b0;
         res_p2 <= '0;
         tag_p2 <= '0;
         err_p2 <= 1'b0;
      end else if (adv_p2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            {err_p2, res_p2} <= calc_p1;
            tag_p2           <= tag_p1;
         end
      end
   end

`ifdef ALU_PIPE_ERR_CNT_EN
   // Increment that sticks at the top of the 8-bit range.
   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   // Count illegal op codes at the moment they are accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= 8'd0;
      end else if (accept && (op_in > 4'd10)) begin
         err_cnt <= sat_inc(err_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe (WIDTH=32, TAG_W=4): directed vector table, backpressure
// and reset sequences, and randomized traffic against a reference model.
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_vld;
   logic        in_rdy;
   logic [3:0]  op_in;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic [3:0]  tag_in;
   logic [31:0] out;
   logic [3:0]  out_tag;
   logic        out_vld;
   logic        out_rdy;
   logic        out_err;
`ifdef ALU_PIPE_ERR_CNT_EN
   logic [7:0]  err_cnt;
`endif

   alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (in_vld),
      .in_rdy  (in_rdy),
      .op_in   (op_in),
      .a_in    (a_in),
      .b_in    (b_in),
      .tag_in  (tag_in),
      .out     (out),
      .out_tag (out_tag),
      .out_vld (out_vld),
      .out_rdy (out_rdy),
      .out_err (out_err)
`ifdef ALU_PIPE_ERR_CNT_EN
      ,
      .err_cnt (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  tag;
      logic        err;
   } beat_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
      logic [31:0] exp_out;
      logic        exp_err;
   } vec_t;

   int          vectors     = 0;
   int          miscompares = 0;
   int          err_model   = 0;
   int          delivered   = 0;
   beat_t       exp_q[$];
   bit          held = 1'b0;
   logic [31:0] h_out;
   logic [3:0]  h_tag;
   logic        h_err;

   localparam longint M32 = 64'h1_0000_0000;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
      end
   endtask

   // Reference result computed with plain 64-bit integer arithmetic.
   function automatic beat_t ref_beat(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [3:0] tag);
      longint ua, ub, sa, sb, r;
      int     sh;
      beat_t  bt;
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      sa = (ua >= M32 / 2) ? ua - M32 : ua;
      sb = (ub >= M32 / 2) ? ub - M32 : ub;
      sh = int'(ub % 32);
      r  = 0;
      bt.err = 1'b0;
      case (op)
         4'd0:  r = 0;
         4'd1:  r = (ua + ub) % M32;
         4'd2:  r = (ua - ub + M32) % M32;
         4'd3:  r = ua & ub;
         4'd4:  r = ua | ub;
         4'd5:  r = ua ^ ub;
         4'd6:  r = (ua * (longint'(1) << sh)) % M32;
         4'd7:  r = ua / (longint'(1) << sh);
         4'd8: begin
            r = sa >>> sh;
            if (r < 0) r = r + M32;
         end
         4'd9:  r = (sa < sb) ? 1 : 0;
         4'd10: r = (ua < ub) ? 1 : 0;
         default: begin
            r = 0;
            bt.err = 1'b1;
         end
      endcase
      bt.res = r[31:0];
      bt.tag = tag;
      return bt;
   endfunction

   // One clock cycle of traffic: drive at the falling edge, score, then advance.
   task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag, input logic ordy,
                       output bit acc);
      beat_t e;
      in_vld = v; op_in = op; a_in = a; b_in = b; tag_in = tag; out_rdy = ordy;
      #1;
      if (held) begin
         check("hold_vld", 64'(out_vld), 64'(1));
         check("hold_out", 64'(out), 64'(h_out));
         check("hold_tag", 64'(out_tag), 64'(h_tag));
         check("hold_err", 64'(out_err), 64'(h_err));
      end
      held  = out_vld && !out_rdy;
      h_out = out; h_tag = out_tag; h_err = out_err;
      if (out_vld && out_rdy) begin
         if (exp_q.size() == 0) begin
            check("extra_beat", 64'(1), 64'(0));
         end else begin
            e = exp_q.pop_front();
            check("beat_out", 64'(out), 64'(e.res));
            check("beat_tag", 64'(out_tag), 64'(e.tag));
            check("beat_err", 64'(out_err), 64'(e.err));
            delivered++;
         end
      end
      acc = in_vld && in_rdy;
      if (acc) begin
         exp_q.push_back(ref_beat(op, a, b, tag));
         if (op > 4'd10 && err_model < 255) err_model++;
      end
      @(posedge clk);
      @(negedge clk);
`ifdef ALU_PIPE_ERR_CNT_EN
      check("err_cnt", 64'(err_cnt), 64'(err_model));
`endif
   endtask

   // Single isolated op with the consumer always ready: checks 2-cycle latency.
   task automatic run_vec(input vec_t v, input int idx);
      in_vld = 1'b1; op_in = v.op; a_in = v.a; b_in = v.b; tag_in = v.tag; out_rdy = 1'b1;
      #1;
      check($sformatf("vec%0d_in_rdy", idx), 64'(in_rdy), 64'(1));
      if (v.op > 4'd10 && err_model < 255) err_model++;
      @(posedge clk);
      @(negedge clk);
      in_vld = 1'b0;
      #1;
      check($sformatf("vec%0d_early_vld", idx), 64'(out_vld), 64'(0));
      @(posedge clk);
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_vld", idx), 64'(out_vld), 64'(1));
      check($sformatf("vec%0d_out", idx), 64'(out), 64'(v.exp_out));
      check($sformatf("vec%0d_tag", idx), 64'(out_tag), 64'(v.tag));
      check($sformatf("vec%0d_err", idx), 64'(out_err), 64'(v.exp_err));
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, need completion");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      vec_t        tbl[16];
      bit          acc;
      int          i;
      int          cyc;
      logic [3:0]  rop;
      logic [31:0] ra, rb;

      tbl[0]  = '{4'd1,  32'hFFFF_FFFF, 32'h0000_0001, 4'd3,  32'h0000_0000, 1'b0};
      tbl[1]  = '{4'd8,  32'h8000_0000, 32'h0000_0024, 4'd5,  32'hF800_0000, 1'b0};
      tbl[2]  = '{4'd9,  32'hFFFF_FFFF, 32'h0000_0000, 4'd6,  32'h0000_0001, 1'b0};
      tbl[3]  = '{4'd10, 32'hFFFF_FFFF, 32'h0000_0000, 4'd7,  32'h0000_0000, 1'b0};
      tbl[4]  = '{4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 4'd8,  32'h0000_0000, 1'b1};
      tbl[5]  = '{4'd2,  32'h0000_0000, 32'h0000_0001, 4'd9,  32'hFFFF_FFFF, 1'b0};
      tbl[6]  = '{4'd6,  32'h0000_0001, 32'h0000_003F, 4'd10, 32'h8000_0000, 1'b0};
      tbl[7]  = '{4'd7,  32'h8000_0000, 32'h0000_0021, 4'd11, 32'h4000_0000, 1'b0};
      tbl[8]  = '{4'd3,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd12, 32'h00F0_00F0, 1'b0};
      tbl[9]  = '{4'd4,  32'h1234_0000, 32'h0000_5678, 4'd13, 32'h1234_5678, 1'b0};
      tbl[10] = '{4'd5,  32'hFFFF_0000, 32'hFF00_FF00, 4'd14, 32'h00FF_FF00, 1'b0};
      tbl[11] = '{4'd0,  32'h0000_0005, 32'h0000_0006, 4'd15, 32'h0000_0000, 1'b0};
      tbl[12] = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1,  32'h0000_0000, 1'b1};
      tbl[13] = '{4'd9,  32'h7FFF_FFFF, 32'h8000_0000, 4'd2,  32'h0000_0000, 1'b0};
      tbl[14] = '{4'd10, 32'h7FFF_FFFF, 32'h8000_0000, 4'd4,  32'h0000_0001, 1'b0};
      tbl[15] = '{4'd8,  32'h7000_0000, 32'hFFFF_FFE4, 4'd0,  32'h0700_0000, 1'b0};

      rst = 1'b1; in_vld = 1'b0; op_in = '0; a_in = '0; b_in = '0; tag_in = '0; out_rdy = 1'b0;
      @(negedge clk);
      #1;
      check("rst_out_vld", 64'(out_vld), 64'(0));
      check("rst_in_rdy", 64'(in_rdy), 64'(1));
      check("rst_out", 64'(out), 64'(0));
      check("rst_out_tag", 64'(out_tag), 64'(0));
      check("rst_out_err", 64'(out_err), 64'(0));
`ifdef ALU_PIPE_ERR_CNT_EN
      check("rst_err_cnt", 64'(err_cnt), 64'(0));
`endif
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Directed vectors, one at a time.
      for (int k = 0; k < 16; k++) begin
         run_vec(tbl[k], k);
`ifdef ALU_PIPE_ERR_CNT_EN
         if (k == 4) check("err_cnt_first", 64'(err_cnt), 64'(1));
`endif
      end

      // Four back-to-back ops into a stalled consumer, then release.
      delivered = 0;
      i = 0;
      for (int c = 0; c < 4; c++) begin
         step(1'b1, 4'd1, 32'h100 + 32'(i), 32'h10 * 32'(i), 4'(i), 1'b0, acc);
         if (acc) i++;
      end
      #1;
      check("bp_accepted", 64'(i), 64'(2));
      check("bp_in_rdy", 64'(in_rdy), 64'(0));
      cyc = 0;
      while ((i < 4 || exp_q.size() > 0) && cyc < 50) begin
         step(i < 4, 4'd1, 32'h100 + 32'(i % 4), 32'h10 * 32'(i % 4), 4'(i % 4), 1'b1, acc);
         if (acc) i++;
         cyc++;
      end
      check("bp_timeout", 64'(cyc < 50), 64'(1));
      check("bp_delivered", 64'(delivered), 64'(4));

      // Reset with both stages occupied.
      step(1'b1, 4'd5, 32'hAAAA_5555, 32'h0F0F_0F0F, 4'd9, 1'b0, acc);
      step(1'b1, 4'd13, 32'h1, 32'h2, 4'd10, 1'b0, acc);
      #1;
      check("pre_rst_in_rdy", 64'(in_rdy), 64'(0));
      in_vld = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_out_vld", 64'(out_vld), 64'(0));
      check("midrst_in_rdy", 64'(in_rdy), 64'(1));
      check("midrst_out", 64'(out), 64'(0));
      check("midrst_out_tag", 64'(out_tag), 64'(0));
      exp_q.delete();
      held = 1'b0;
      err_model = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, acc);
         check("post_rst_out_vld", 64'(out_vld), 64'(0));
      end

      // Randomized traffic with random backpressure.
      delivered = 0;
      for (int c = 0; c < 800; c++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         rb  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         step($urandom_range(0, 3) != 0, rop, ra, rb, 4'($urandom), $urandom_range(0, 2) != 0, acc);
      end
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 10) begin
         step(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, acc);
         cyc++;
      end
      check("rand_drained", 64'(exp_q.size()), 64'(0));

      // 300 illegal ops: error count must saturate.
      for (int c = 0; c < 300; c++) begin
         step(1'b1, 4'd12, $urandom, $urandom, 4'(c), 1'b1, acc);
      end
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 10) begin
         step(1'b0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1, acc);
         cyc++;
      end
      check("illegal_drained", 64'(exp_q.size()), 64'(0));
`ifdef ALU_PIPE_ERR_CNT_EN
      check("err_cnt_sat", 64'(err_cnt), 64'(255));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
